// File: rtl/ima_adpcm_decoder.sv
// Streaming IMA ADPCM decoder: one 4-bit nibble in, one 16-bit PCM sample out per clock.
// Define IMA_ADPCM_VALID_OUT_EN to add the registered valid_o output.
module ima_adpcm_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sop,
    input  logic        eop,
    input  logic [3:0]  coded_i,
`ifdef IMA_ADPCM_VALID_OUT_EN
    output logic        valid_o,
`endif
    output logic [15:0] decoded_o
);

    localparam int DATA_W = 16;
    localparam int PROD_W = 21;
    localparam int ACC_W  = 18;
    localparam logic [6:0] IDX_MAX = 7'd88;

    localparam logic [DATA_W-1:0] STEP_TAB [89] = '{
        7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
        19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
        50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
        130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
        337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
        876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
        2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
        5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
        15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
    };

    function automatic logic signed [4:0] idx_adj(input logic [2:0] mag);
        case (mag)
            3'd4:    return 5'sd2;
            3'd5:    return 5'sd4;
            3'd6:    return 5'sd6;
            3'd7:    return 5'sd8;
            default: return -5'sd1;
        endcase
    endfunction

    function automatic logic [6:0] clamp_idx(input logic signed [8:0] x);
        if (x < 9'sd0)
            return 7'd0;
        else if (x > 9'sd88)
            return IDX_MAX;
        else
            return x[6:0];
    endfunction

    // Signed divide by 8 truncating toward zero: bias negatives by 7 before the shift.
    function automatic logic signed [ACC_W-1:0] div8_trunc(input logic signed [PROD_W-1:0] p);
        logic signed [PROD_W-1:0] biased;
        biased = p + (p[PROD_W-1] ? 21'sd7 : 21'sd0);
        return ACC_W'(biased >>> 3);
    endfunction

    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] x);
        if (x > 18'sd32767)
            return 16'sh7FFF;
        else if (x < -18'sd32768)
            return 16'sh8000;
        else
            return x[DATA_W-1:0];
    endfunction

    logic signed [DATA_W-1:0] pred_p0;
    logic [6:0]               idx_p0;
    logic [DATA_W-1:0]        step_p0;
    logic                     in_pkt;

    logic                     proc;
    logic signed [DATA_W-1:0] base_pred;
    logic [6:0]               base_idx;
    logic [DATA_W-1:0]        base_step;
    logic signed [4:0]        adj;
    logic signed [8:0]        idx_sum;
    logic [6:0]               idx_new;
    logic [4:0]               mag2;
    logic signed [4:0]        two_v1;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  diff;
    logic signed [ACC_W-1:0]  sum;
    logic signed [DATA_W-1:0] pred_next;

    assign proc = sop | in_pkt;

    always_comb begin
        base_pred = pred_p0;
        base_idx  = idx_p0;
        base_step = step_p0;
        if (sop) begin
            base_pred = '0;
            base_idx  = '0;
            base_step = 16'd7;
        end
        adj     = idx_adj(coded_i[2:0]);
        idx_sum = $signed({2'b00, base_idx}) + {{4{adj[4]}}, adj};
        idx_new = clamp_idx(idx_sum);
        // 2*v+1 with v = +/-mag, ranges -13..15
        mag2    = {1'b0, coded_i[2:0], 1'b0};
        two_v1  = coded_i[3] ? (5'sd1 - $signed(mag2)) : ($signed(mag2) + 5'sd1);
        prod    = $signed({{16{two_v1[4]}}, two_v1}) * $signed({5'b00000, base_step});
        diff    = div8_trunc(prod);
        sum     = $signed({{2{base_pred[DATA_W-1]}}, base_pred}) + diff;
        pred_next = sat16(sum);
    end

    // Stage p0: decoder state and output sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_p0 <= '0;
            idx_p0  <= '0;
            step_p0 <= 16'd7;
            in_pkt  <= 1'b0;
        end else if (proc) begin
            pred_p0 <= pred_next;
            idx_p0  <= idx_new;
            step_p0 <= STEP_TAB[idx_new];
            in_pkt  <= ~eop;
        end
    end

    assign decoded_o = pred_p0;

`ifdef IMA_ADPCM_VALID_OUT_EN
    logic vld_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p0 <= 1'b0;
        else
            vld_p0 <= proc;
    end

    assign valid_o = vld_p0;
`endif

endmodule

// File: tb/tb_ima_adpcm_decoder.sv
// Directed and random-packet bench for ima_adpcm_decoder against an integer reference model.
module tb_ima_adpcm_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sop;
    logic        eop;
    logic [3:0]  coded_i;
    logic [15:0] decoded_o;
`ifdef IMA_ADPCM_VALID_OUT_EN
    logic        valid_o;
`endif

    int checks   = 0;
    int failures = 0;

    ima_adpcm_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sop       (sop),
        .eop       (eop),
        .coded_i   (coded_i),
`ifdef IMA_ADPCM_VALID_OUT_EN
        .valid_o   (valid_o),
`endif
        .decoded_o (decoded_o)
    );

    always #5 clk = ~clk;

    int steps [89] = '{
        7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
        19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
        50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
        130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
        337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
        876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
        2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
        5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
        15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
    };
    int idx_tab [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

    int m_pred   = 0;
    int m_idx    = 0;
    int m_in_pkt = 0;
    int m_vld    = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic model_step(input bit s, input bit e, input logic [3:0] n);
        int step_old, mag, v, diff;
        if (s || m_in_pkt != 0) begin
            if (s) begin
                m_pred = 0;
                m_idx  = 0;
            end
            step_old = steps[m_idx];
            mag      = int'(n[2:0]);
            m_idx    = m_idx + idx_tab[mag];
            if (m_idx < 0)  m_idx = 0;
            if (m_idx > 88) m_idx = 88;
            v    = n[3] ? -mag : mag;
            diff = ((2 * v + 1) * step_old) / 8;
            m_pred = m_pred + diff;
            if (m_pred > 32767)  m_pred = 32767;
            if (m_pred < -32768) m_pred = -32768;
            m_in_pkt = e ? 0 : 1;
            m_vld    = 1;
        end else begin
            m_vld = 0;
        end
    endtask

    // Drive one nibble from a negedge, update the model at the edge, compare just after.
    task automatic cyc(input bit s, input bit e, input logic [3:0] n, input string tag);
        sop     = s;
        eop     = e;
        coded_i = n;
        @(posedge clk);
        model_step(s, e, n);
        #1;
        check(tag, {16'h0, decoded_o}, {16'h0, 16'(m_pred)});
`ifdef IMA_ADPCM_VALID_OUT_EN
        check({tag, "_vld"}, {31'h0, valid_o}, 32'(m_vld));
`endif
        @(negedge clk);
    endtask

    initial begin
        logic signed [15:0] prev;
        logic [3:0] nib;

        rst_n   = 1'b0;
        sop     = 1'b0;
        eop     = 1'b0;
        coded_i = 4'h0;
        repeat (2) @(negedge clk);
        check("reset_out", {16'h0, decoded_o}, 32'h0);
`ifdef IMA_ADPCM_VALID_OUT_EN
        check("reset_vld", {31'h0, valid_o}, 32'h0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Idle nibbles before any sop are ignored
        cyc(0, 0, 4'h7, "idle_pre");
        cyc(1, 0, 4'h4, "first_sop");
        check("first_lit", {16'h0, decoded_o}, 32'h0007);
        cyc(0, 0, 4'hC, "neg_nib");
        check("neg_lit", {16'h0, decoded_o}, 32'h0000);
        cyc(1, 0, 4'h1, "sop_clamp");
        check("clamp_lit", {16'h0, decoded_o}, 32'h0002);
        cyc(1, 0, 4'h8, "sop_zero");
        check("zero_lit", {16'h0, decoded_o}, 32'h0000);

        // Positive saturation
        cyc(1, 0, 4'h7, "sat_pos");
        prev = $signed(decoded_o);
        for (int i = 1; i < 40; i++) begin
            cyc(0, i == 39, 4'h7, "sat_pos");
            check("mono_up", {31'h0, $signed(decoded_o) >= prev}, 32'h1);
            prev = $signed(decoded_o);
        end
        check("sat_pos_lit", {16'h0, decoded_o}, 32'h7FFF);

        // Negative saturation, then hold after eop
        for (int i = 0; i < 40; i++)
            cyc(i == 0, i == 39, 4'hF, "sat_neg");
        check("sat_neg_lit", {16'h0, decoded_o}, 32'h8000);
        cyc(0, 0, 4'h7, "post_eop_hold");
        check("hold_lit", {16'h0, decoded_o}, 32'h8000);

        // One-nibble packet then ignored nibbles
        cyc(1, 1, 4'h4, "one_nib");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 4'h7, "one_nib_hold");
        check("one_nib_lit", {16'h0, decoded_o}, 32'h0007);

        // Mid-packet restart
        cyc(1, 0, 4'h7, "mid_a");
        cyc(0, 0, 4'h7, "mid_b");
        cyc(1, 0, 4'h4, "mid_sop");
        check("mid_sop_lit", {16'h0, decoded_o}, 32'h0007);
        cyc(0, 0, 4'h6, "mid_c");

        // Asynchronous reset mid-packet
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", {16'h0, decoded_o}, 32'h0);
        m_pred = 0; m_idx = 0; m_in_pkt = 0; m_vld = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cyc(0, 0, 4'h7, "post_rst_ign");
        cyc(0, 1, 4'h5, "post_rst_ign");
        check("post_rst_lit", {16'h0, decoded_o}, 32'h0);
        cyc(1, 0, 4'h4, "post_rst_sop");
        check("post_rst_sop_lit", {16'h0, decoded_o}, 32'h0007);

        // Random 1000-nibble packet
        for (int i = 0; i < 1000; i++) begin
            nib = 4'($urandom_range(15, 0));
            cyc(i == 0, i == 999, nib, "rand");
        end
        cyc(0, 0, 4'h3, "rand_tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ima_adpcm_decoder.md
Name: ima_adpcm_decoder

Overview:
- Streaming IMA ADPCM decoder: converts one 4-bit coded nibble per clock into one 16-bit signed PCM sample.
- Packets are framed by sop/eop. Decoder state (predictor, step index) restarts at each sop.
- Sits between the compressed-audio source and the PCM sink; no backpressure.

Parameters:
- None. Index table, 89-entry step table (7 … 32767, standard IMA values) and widths are fixed constants.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- sop  input  1  start of packet; coded_i on this cycle is the first nibble
- eop  input  1  end of packet; coded_i on this cycle is the last nibble
- coded_i  input  4  coded nibble: bit3 = sign, bits2:0 = magnitude
- decoded_o  output  16  decoded sample, two's complement, registered

Behaviour:
- Reset (async, rst_n=0): predictor=0, step_index=0, step=7, in_pkt=0, decoded_o=16'h0000.
- Nibble acceptance:
  - A nibble is processed on a rising edge when sop=1, or when in_pkt=1.
  - sop=1 sets in_pkt=1. eop=1 on a processed cycle clears in_pkt after that nibble.
  - sop and eop together form a one-nibble packet.
  - Nibbles outside a packet are ignored; state and decoded_o hold.
- On sop: the nibble is decoded from predictor=0, step_index=0, step=7, as if just reset.
- sop while already in_pkt restarts the packet the same way.
- Per processed nibble, all in one cycle, in this order:
  - step_index += idx_tab[n]; idx_tab = -1,-1,-1,-1,2,4,6,8 indexed by bits2:0 (sign ignored). Clamp step_index to 0..88.
  - Signed value v = bit3 ? -mag : +mag, so v ranges -7..+7 (nibble 8 gives v=0).
  - diff = ((2*v+1) * step_old) / 8, where step_old is the step before this nibble's update.
    - Signed division truncates toward zero; this is not an arithmetic shift.
    - The product range -425971..491505 needs at least 20-bit signed arithmetic.
  - predictor += diff; saturate to [-32768, 32767]. Use at least 18-bit intermediate.
  - step = step_tab[new step_index].
  - decoded_o <= predictor[15:0].
- Latency: decoded_o shows the nibble sampled at edge k immediately after edge k (one register stage). Full throughput: one sample per cycle.
- Saturation is sticky per value only: the predictor simply sits at the rail until diff pulls it back.
- Reset mid-packet aborts the packet. Nibbles are ignored until the next sop.

Optional Feature:
- Macro IMA_ADPCM_VALID_OUT_EN.
- Defined: adds output valid_o (1 bit, reset 0). valid_o is registered high for exactly the cycles where decoded_o was updated by a processed nibble, and low otherwise.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then sop with coded_i=4 -> decoded_o=0x0007 after the edge; internal step_index=2, step=9.
- Continue with coded_i=0xC -> diff=-63/8=-7 -> decoded_o=0x0000; step_index=4, step=11.
- New sop with coded_i=1 -> step_index clamps to 0, diff=21/8=2 -> decoded_o=0x0002. Then sop with coded_i=8 -> v=0, diff=7/8=0 -> decoded_o=0x0000.
- Packet of 40 nibbles of 7 -> decoded_o rises monotonically and saturates at 0x7FFF. A packet of 40 of 0xF saturates at 0x8000 and holds.
- Sequences around eop:
  - sop=eop=1 with coded_i=4 -> 0x0007; following nibbles without sop -> decoded_o holds 0x0007.
  - Mid-packet sop with coded_i=4 -> 0x0007 (state restart).
  - rst_n pulse mid-packet -> decoded_o=0 immediately (async); later nibbles ignored until sop.
- Random 1000-nibble packet -> decoded_o matches a software model using the equations above, cycle for cycle, with zero mismatches.
